// File: rtl/regfile_pkg.sv
// Shared widths, well-known register indices and types for the MIPS register file.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
  localparam reg_idx_t REG_V0   = reg_idx_t'(2);
  localparam reg_idx_t REG_A0   = reg_idx_t'(4);

  // Output slots driven by the read-port array in the top.
  localparam int NUM_PORTS = 4;
  localparam int PORT_R1   = 0;
  localparam int PORT_R2   = 1;
  localparam int PORT_A0   = 2;
  localparam int PORT_V0   = 3;

  typedef struct packed {
    logic     en;
    reg_idx_t idx;
    data_t    data;
  } wr_req_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read mux over the register view; index 0 always reads zero.
// With RF_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  rd_idx,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_idx,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  rd_data
);

`ifdef RF_BYPASS_EN
  always_comb begin
    rd_data = (rd_idx == '0) ? '0 : regs[rd_idx];
    // wr_en already excludes reset, so a dropped write never forwards.
    if (wr_en && (wr_idx != '0) && (wr_idx == rd_idx))
      rd_data = wr_data;
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_idx, wr_data};

  always_comb begin
    rd_data = (rd_idx == '0) ? '0 : regs[rd_idx];
  end
`endif

endmodule

// File: rtl/register_file.sv
// 32x32 MIPS register file: two read ports, one write port, $a0/$v0 taps, r0 hardwired to 0.
// Optional write-through forwarding when RF_BYPASS_EN is defined.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg1_number,
  input  logic [ADDR_W-1:0] reg2_number,
  input  logic [ADDR_W-1:0] write_reg_number,
  input  logic [DATA_W-1:0] write_data,
  input  logic              WE,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] v0
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:1][DATA_W-1:0]              regs;
  logic [NREG-1:0][DATA_W-1:0]              regs_view;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]         rd_idx;
  logic [NUM_PORTS-1:0][DATA_W-1:0]         rd_data;
  logic                                     wr_live;

  // Reset wins over a concurrent write; r0 has no storage so its writes vanish.
  always_ff @(posedge clk) begin
    if (rst)
      regs <= '0;
    else if (WE && (write_reg_number != '0))
      regs[write_reg_number] <= write_data;
  end

  assign regs_view = {regs, {DATA_W{1'b0}}};
  assign wr_live   = WE & ~rst;

  assign rd_idx[PORT_R1] = reg1_number;
  assign rd_idx[PORT_R2] = reg2_number;
  assign rd_idx[PORT_A0] = ADDR_W'(REG_A0);
  assign rd_idx[PORT_V0] = ADDR_W'(REG_V0);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .regs    (regs_view),
      .rd_idx  (rd_idx[p]),
      .wr_en   (wr_live),
      .wr_idx  (write_reg_number),
      .wr_data (write_data),
      .rd_data (rd_data[p])
    );
  end

  assign reg1 = rd_data[PORT_R1];
  assign reg2 = rd_data[PORT_R2];
  assign a0   = rd_data[PORT_A0];
  assign v0   = rd_data[PORT_V0];

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized check of register_file against an array model of the registers.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg1_number, reg2_number, write_reg_number;
  logic [31:0] write_data;
  logic        WE;
  logic [31:0] reg1, reg2, a0, v0;

  logic [31:0] model [32];
  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk              (clk),
    .rst              (rst),
    .reg1_number      (reg1_number),
    .reg2_number      (reg2_number),
    .write_reg_number (write_reg_number),
    .write_data       (write_data),
    .WE               (WE),
    .reg1             (reg1),
    .reg2             (reg2),
    .a0               (a0),
    .v0               (v0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // What a read of idx should show right now, before the next edge.
  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    logic [31:0] v;
    v = (idx == 0) ? 32'h0 : model[idx];
`ifdef RF_BYPASS_EN
    if (WE && !rst && write_reg_number != 0 && write_reg_number == idx)
      v = write_data;
`endif
    return v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (WE && write_reg_number != 0) begin
      model[write_reg_number] = write_data;
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [4:0] widx,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rst = r; WE = we; write_reg_number = widx; write_data = wd;
    reg1_number = r1; reg2_number = r2;
    #1;
    chk("reg1", reg1, exp_rd(r1));
    chk("reg2", reg2, exp_rd(r2));
    chk("a0",   a0,   exp_rd(5'd4));
    chk("v0",   v0,   exp_rd(5'd2));
    @(posedge clk);
    model_edge();
  endtask

  task automatic peek(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] ea0, input logic [31:0] ev0);
    @(negedge clk);
    rst = 1'b0; WE = 1'b0; reg1_number = r1; reg2_number = r2;
    #1;
    chk({tag, "_reg1"}, reg1, e1);
    chk({tag, "_reg2"}, reg2, e2);
    chk({tag, "_a0"},   a0,   ea0);
    chk({tag, "_v0"},   v0,   ev0);
  endtask

  initial begin
    logic [4:0] pick [3];
    pick[0] = 5'd0; pick[1] = 5'd2; pick[2] = 5'd4;

    rst = 1'b1; WE = 1'b0; write_reg_number = '0; write_data = '0;
    reg1_number = '0; reg2_number = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    repeat (2) @(posedge clk);
    peek("por", 5'd1, 5'd31, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset clears prior contents
    step(0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    peek("pre_rst", 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    step(1, 0, 5'd0, 32'h0, 5'd5, 5'd0);
    peek("rst_clr", 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Basic write/read and taps
    step(0, 1, 5'd4, 32'hAAAABBBB, 5'd4, 5'd2);
    step(0, 1, 5'd2, 32'h12345678, 5'd4, 5'd2);
    peek("basic", 5'd4, 5'd2, 32'hAAAABBBB, 32'h12345678, 32'hAAAABBBB, 32'h12345678);

    // r0 hardwired
    step(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    peek("r0", 5'd0, 5'd0, 32'h0, 32'h0, 32'hAAAABBBB, 32'h12345678);

    // WE gating
    step(0, 0, 5'd7, 32'h55555555, 5'd7, 5'd7);
    peek("we_gate", 5'd7, 5'd7, 32'h0, 32'h0, 32'hAAAABBBB, 32'h12345678);

    // Read-during-write on r2
    step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0; WE = 1'b1; write_reg_number = 5'd2; write_data = 32'h11111111;
    reg1_number = 5'd2; reg2_number = 5'd0;
    #1;
`ifdef RF_BYPASS_EN
    chk("rdw_pre_reg1", reg1, 32'h11111111);
    chk("rdw_pre_v0",   v0,   32'h11111111);
`else
    chk("rdw_pre_reg1", reg1, 32'h0);
    chk("rdw_pre_v0",   v0,   32'h0);
`endif
    chk("rdw_pre_reg2", reg2, 32'h0);
    @(posedge clk);
    model_edge();
    peek("rdw_post", 5'd2, 5'd2, 32'h11111111, 32'h11111111, 32'h0, 32'h11111111);

    // Reset priority over a same-cycle write
    step(0, 1, 5'd4, 32'hCAFEF00D, 5'd4, 5'd0);
    step(1, 1, 5'd4, 32'h12341234, 5'd4, 5'd4);
    peek("rst_prio", 5'd4, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0);

    // Randomized traffic, biased toward r0 and the tap registers
    for (int n = 0; n < 400; n++) begin
      logic       r, we;
      logic [4:0] w, a, b;
      r  = ($urandom_range(0, 39) == 0);
      we = $urandom_range(0, 1);
      w  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 2)] : 5'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? w : 5'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 2)] : 5'($urandom);
      step(r, we, w, $urandom, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
